// File: rtl/serial_bit_feeder_if.sv
// Word handshake into serial_bit_feeder and the serial bit stream it produces.
interface serial_bit_feeder_if #(
   parameter int unsigned WIDTH = 5
);
   logic [WIDTH-1:0] word_in;
   logic             word_valid;
   logic             word_ready;
   logic             bit_out;
   logic             bit_valid;
   logic             word_done;
   logic             busy;

   modport master (
      output word_in, word_valid,
      input  word_ready, bit_out, bit_valid, word_done, busy
   );

   modport slave (
      input  word_in, word_valid,
      output word_ready, bit_out, bit_valid, word_done, busy
   );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-word to serial-bit feeder, one bit per clock, gapless back-to-back words.
// Define SERIAL_PARITY_EN to append an even-parity bit after each word.
module serial_bit_feeder #(
   parameter int unsigned WIDTH     = 5,
   parameter logic        MSB_FIRST = 1'b1
) (
   input logic                clock,
   input logic                reset,
   serial_bit_feeder_if.slave bus
);

   localparam int unsigned   CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, PARITY = 2'b10} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bit_out_q, bit_out_d;
   logic             bit_valid_q, bit_valid_d;
   logic             word_done_q, word_done_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] word_in_rev;
   logic [WIDTH-1:0] word_in_ord;
   logic             word_ready;
   logic             accept;

   // Words are stored in transmit order so the counter always indexes bit 0 first.
   always_comb begin
      word_in_rev = {<<{bus.word_in}};
      word_in_ord = MSB_FIRST ? word_in_rev : bus.word_in;
   end

   always_comb begin
      word_ready = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE:    word_ready = 1'b1;
`ifdef SERIAL_PARITY_EN
            PARITY:  word_ready = 1'b1;
`else
            SHIFT:   word_ready = (cnt_q == LAST);
`endif
            default: word_ready = 1'b0;
         endcase
      end
   end

   always_comb begin
      accept = bus.word_valid && word_ready;
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               word_d  = word_in_ord;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (cnt_q != LAST) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
`ifdef SERIAL_PARITY_EN
               state_d = PARITY;
`else
               if (accept) begin
                  state_d = SHIFT;
                  word_d  = word_in_ord;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
`endif
            end
         end
`ifdef SERIAL_PARITY_EN
         PARITY: begin
            if (accept) begin
               state_d = SHIFT;
               word_d  = word_in_ord;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            word_d  = '0;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      bit_valid_d = (state_d != IDLE);
      busy_d      = (state_d != IDLE);
      bit_out_d   = 1'b0;
      word_done_d = 1'b0;
      if (state_d == SHIFT) begin
         bit_out_d = word_d[cnt_d];
`ifndef SERIAL_PARITY_EN
         word_done_d = (cnt_d == LAST);
`endif
      end
`ifdef SERIAL_PARITY_EN
      if (state_d == PARITY) begin
         bit_out_d   = ^word_d;
         word_done_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         word_q      <= '0;
         cnt_q       <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         word_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         cnt_q       <= cnt_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         word_done_q <= word_done_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      bus.word_ready = word_ready;
      bus.bit_out    = bit_out_q;
      bus.bit_valid  = bit_valid_q;
      bus.word_done  = word_done_q;
      bus.busy       = busy_q;
   end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Testbench for serial_bit_feeder: MSB-first and LSB-first instances run in lockstep.
// Status vectors are {word_ready, bit_out, bit_valid, word_done, busy}.
`timescale 1ns/1ps
module tb_serial_bit_feeder;

   localparam int unsigned W = 5;
`ifdef SERIAL_PARITY_EN
   localparam int unsigned SLOTS = W + 1;
`else
   localparam int unsigned SLOTS = W;
`endif
   localparam logic [4:0] IDLE_ST  = 5'b10000;
   localparam logic [4:0] RESET_ST = 5'b00000;

   logic clock = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;

   serial_bit_feeder_if #(.WIDTH(W)) bm ();
   serial_bit_feeder_if #(.WIDTH(W)) bl ();

   serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clock(clock), .reset(reset), .bus(bm));
   serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clock(clock), .reset(reset), .bus(bl));

   always #5 clock = ~clock;

   function automatic logic [4:0] st_m();
      return {bm.word_ready, bm.bit_out, bm.bit_valid, bm.word_done, bm.busy};
   endfunction

   function automatic logic [4:0] st_l();
      return {bl.word_ready, bl.bit_out, bl.bit_valid, bl.word_done, bl.busy};
   endfunction

   // Reference: slot s of a word is data bit s in transmit order, slot W is even parity.
   function automatic logic slot_bit(logic [W-1:0] w, bit msb, int unsigned s);
      logic [W-1:0] r;
      if (s >= W) return ^w;
      r = msb ? (w >> (W - 1 - s)) : (w >> s);
      return r[0];
   endfunction

   function automatic logic [4:0] busy_status(logic [W-1:0] w, bit msb, int unsigned s);
      logic last;
      last = (s == SLOTS - 1);
      return {last, slot_bit(w, msb, s), 1'b1, last, 1'b1};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(logic v, logic [W-1:0] w);
      bm.word_valid = v;
      bm.word_in    = w;
      bl.word_valid = v;
      bl.word_in    = w;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 5'b10110);
      tick();
      tick();
      vectors += 2;
      if (st_m() !== RESET_ST) begin miscompares++; $display("FAIL reset_hold msb: got %b expected %b", st_m(), RESET_ST); end
      if (st_l() !== RESET_ST) begin miscompares++; $display("FAIL reset_hold lsb: got %b expected %b", st_l(), RESET_ST); end
      drive(1'b0, '0);
      reset = 1'b0;
      #1;
      tick();
      vectors += 2;
      if (st_m() !== IDLE_ST) begin miscompares++; $display("FAIL reset_release msb: got %b expected %b", st_m(), IDLE_ST); end
      if (st_l() !== IDLE_ST) begin miscompares++; $display("FAIL reset_release lsb: got %b expected %b", st_l(), IDLE_ST); end
   endtask

   task automatic test_single_word();
      logic [W-1:0] w;
      w = 5'b10110;
      drive(1'b1, w);
      tick();
      drive(1'b0, 5'b01001);
      for (int unsigned s = 0; s < SLOTS; s++) begin
         vectors += 2;
         if (st_m() !== busy_status(w, 1'b1, s)) begin miscompares++; $display("FAIL single_word msb slot %0d: got %b expected %b", s, st_m(), busy_status(w, 1'b1, s)); end
         if (st_l() !== busy_status(w, 1'b0, s)) begin miscompares++; $display("FAIL single_word lsb slot %0d: got %b expected %b", s, st_l(), busy_status(w, 1'b0, s)); end
         tick();
      end
      vectors += 2;
      if (st_m() !== IDLE_ST) begin miscompares++; $display("FAIL single_word_end msb: got %b expected %b", st_m(), IDLE_ST); end
      if (st_l() !== IDLE_ST) begin miscompares++; $display("FAIL single_word_end lsb: got %b expected %b", st_l(), IDLE_ST); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] words [2];
      words[0] = 5'b10110;
      words[1] = 5'b01101;
      drive(1'b1, words[0]);
      tick();
      drive(1'b1, words[1]);
      for (int unsigned k = 0; k < 2; k++) begin
         for (int unsigned s = 0; s < SLOTS; s++) begin
            vectors += 2;
            if (st_m() !== busy_status(words[k], 1'b1, s)) begin miscompares++; $display("FAIL back_to_back msb word %0d slot %0d: got %b expected %b", k, s, st_m(), busy_status(words[k], 1'b1, s)); end
            if (st_l() !== busy_status(words[k], 1'b0, s)) begin miscompares++; $display("FAIL back_to_back lsb word %0d slot %0d: got %b expected %b", k, s, st_l(), busy_status(words[k], 1'b0, s)); end
            tick();
            if (k == 0 && s == SLOTS - 1) drive(1'b0, 5'b11100);
         end
      end
      vectors += 2;
      if (st_m() !== IDLE_ST) begin miscompares++; $display("FAIL back_to_back_end msb: got %b expected %b", st_m(), IDLE_ST); end
      if (st_l() !== IDLE_ST) begin miscompares++; $display("FAIL back_to_back_end lsb: got %b expected %b", st_l(), IDLE_ST); end
   endtask

   task automatic test_stall();
      logic [W-1:0] w;
      drive(1'b0, 5'b11011);
      for (int unsigned c = 0; c < 4; c++) begin
         vectors += 2;
         if (st_m() !== IDLE_ST) begin miscompares++; $display("FAIL stall msb cycle %0d: got %b expected %b", c, st_m(), IDLE_ST); end
         if (st_l() !== IDLE_ST) begin miscompares++; $display("FAIL stall lsb cycle %0d: got %b expected %b", c, st_l(), IDLE_ST); end
         tick();
      end
      w = W'($urandom);
      drive(1'b1, w);
      tick();
      drive(1'b0, ~w);
      for (int unsigned s = 0; s < SLOTS; s++) begin
         vectors += 2;
         if (st_m() !== busy_status(w, 1'b1, s)) begin miscompares++; $display("FAIL stall_resume msb slot %0d: got %b expected %b", s, st_m(), busy_status(w, 1'b1, s)); end
         if (st_l() !== busy_status(w, 1'b0, s)) begin miscompares++; $display("FAIL stall_resume lsb slot %0d: got %b expected %b", s, st_l(), busy_status(w, 1'b0, s)); end
         tick();
      end
   endtask

   task automatic test_reset_mid_word();
      logic [W-1:0] w;
      w = 5'b11111;
      drive(1'b1, w);
      tick();
      drive(1'b0, '0);
      tick();
      tick();
      vectors += 2;
      if (st_m() !== busy_status(w, 1'b1, 2)) begin miscompares++; $display("FAIL mid_word_pre msb: got %b expected %b", st_m(), busy_status(w, 1'b1, 2)); end
      if (st_l() !== busy_status(w, 1'b0, 2)) begin miscompares++; $display("FAIL mid_word_pre lsb: got %b expected %b", st_l(), busy_status(w, 1'b0, 2)); end
      reset = 1'b1;
      #1;
      vectors += 2;
      if (st_m() !== RESET_ST) begin miscompares++; $display("FAIL mid_word_reset msb: got %b expected %b", st_m(), RESET_ST); end
      if (st_l() !== RESET_ST) begin miscompares++; $display("FAIL mid_word_reset lsb: got %b expected %b", st_l(), RESET_ST); end
      tick();
      reset = 1'b0;
      #1;
      vectors += 2;
      if (st_m() !== IDLE_ST) begin miscompares++; $display("FAIL mid_word_release msb: got %b expected %b", st_m(), IDLE_ST); end
      if (st_l() !== IDLE_ST) begin miscompares++; $display("FAIL mid_word_release lsb: got %b expected %b", st_l(), IDLE_ST); end
      w = 5'b10110;
      drive(1'b1, w);
      tick();
      drive(1'b0, '0);
      for (int unsigned s = 0; s < SLOTS; s++) begin
         vectors += 2;
         if (st_m() !== busy_status(w, 1'b1, s)) begin miscompares++; $display("FAIL mid_word_restart msb slot %0d: got %b expected %b", s, st_m(), busy_status(w, 1'b1, s)); end
         if (st_l() !== busy_status(w, 1'b0, s)) begin miscompares++; $display("FAIL mid_word_restart lsb slot %0d: got %b expected %b", s, st_l(), busy_status(w, 1'b0, s)); end
         tick();
      end
   endtask

   task automatic test_random(int unsigned n);
      logic [W-1:0] cur_w, w;
      int unsigned  cur_s;
      bit           active, pending, v, exp_ready;
      logic [4:0]   exp_m, exp_l;
      active  = 1'b0;
      pending = 1'b0;
      cur_w   = '0;
      cur_s   = 0;
      v       = 1'b0;
      w       = '0;
      drive(1'b0, '0);
      for (int unsigned c = 0; c < n; c++) begin
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            #1;
            vectors += 2;
            if (st_m() !== RESET_ST) begin miscompares++; $display("FAIL random_reset msb cycle %0d: got %b expected %b", c, st_m(), RESET_ST); end
            if (st_l() !== RESET_ST) begin miscompares++; $display("FAIL random_reset lsb cycle %0d: got %b expected %b", c, st_l(), RESET_ST); end
            active  = 1'b0;
            pending = 1'b0;
            drive(1'b0, '0);
            tick();
            reset = 1'b0;
            #1;
         end
         exp_m = active ? busy_status(cur_w, 1'b1, cur_s) : IDLE_ST;
         exp_l = active ? busy_status(cur_w, 1'b0, cur_s) : IDLE_ST;
         vectors += 2;
         if (st_m() !== exp_m) begin miscompares++; $display("FAIL random msb cycle %0d: got %b expected %b", c, st_m(), exp_m); end
         if (st_l() !== exp_l) begin miscompares++; $display("FAIL random lsb cycle %0d: got %b expected %b", c, st_l(), exp_l); end
         exp_ready = !active || (cur_s == SLOTS - 1);
         // An offered word stays on the bus unchanged until it is taken.
         if (!pending) begin
            v = ($urandom_range(0, 2) != 0);
            w = W'($urandom);
         end
         pending = v;
         drive(v, w);
         @(posedge clock);
         if (active) begin
            if (cur_s == SLOTS - 1) active = 1'b0;
            else cur_s++;
         end
         if (v && exp_ready) begin
            active  = 1'b1;
            cur_w   = w;
            cur_s   = 0;
            pending = 1'b0;
         end
         #1;
      end
      drive(1'b0, '0);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, '0);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_stall();
      test_reset_mid_word();
      test_random(400);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
